// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline hazard logic: forwarding select
// encodings and the mult/div busy-timer state type.
package mips_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic {
    MD_IDLE,
    MD_BUSY
  } md_state_t;

endpackage

// File: rtl/md_busy_timer.sv
// Mult/div busy timer: tracks the cycles until HI/LO become valid after a
// mult/div instruction enters E.
module md_busy_timer
  import mips_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic hold,
  output logic md_busy,
  output logic start_now
);

  localparam logic MULTI_CYCLE = (MD_LATENCY > 1);

  md_state_t        state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;

  // A held E stage means the mult/div has not really entered E yet.
  assign start_now = start & ~hold & MULTI_CYCLE;
  assign md_busy   = (state == MD_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= MD_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    unique case (state)
      MD_IDLE: begin
        if (start_now) begin
          state_next = MD_BUSY;
          cnt_next   = CNT_W'(MD_LATENCY - 1);
        end
      end
      MD_BUSY: begin
        // The unit runs on its own, so the countdown ignores pipeline stalls.
        if (cnt == CNT_W'(1)) begin
          state_next = MD_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next = MD_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the 5-stage MIPS core: forwarding
// selects, stall/flush controls and mult/div sequencing.
module hazard_ctrl
  import mips_pkg::*;
#(
  parameter int unsigned MD_LATENCY = 4,
  parameter int unsigned CNT_W      = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rsd,
  input  logic [4:0] rtd,
  input  logic [4:0] rse,
  input  logic [4:0] rte,
  input  logic [4:0] writerege,
  input  logic [4:0] writeregm,
  input  logic [4:0] writeregw,
  input  logic       regwritee,
  input  logic       regwritem,
  input  logic       regwritew,
  input  logic       memtorege,
  input  logic       memtoregm,
  input  logic       branchd,
  input  logic       pcsrcd,
  input  logic       mdopd,
  input  logic       hiloreadd,
  input  logic       mdstarte,
  input  logic       dmem_ready,
  output logic       stallf,
  output logic       stalld,
  output logic       stalle,
  output logic       stallm,
  output logic       flushd,
  output logic       flushe,
  output logic       forwardad,
  output logic       forwardbd,
  output logic [1:0] forwardae,
  output logic [1:0] forwardbe,
  output logic       md_busy
);

  logic start_now;
  logic lwstall, branchstall, mdstall, memstall, stall_any;
  logic hit_e, hit_m;

  md_busy_timer #(
    .MD_LATENCY(MD_LATENCY),
    .CNT_W     (CNT_W)
  ) u_md_timer (
    .clk      (clk),
    .rst      (rst),
    .start    (mdstarte),
    .hold     (stalle),
    .md_busy  (md_busy),
    .start_now(start_now)
  );

  always_comb begin
    memstall = ~dmem_ready;
    // lwstall deliberately matches $0 too; the extra bubble is harmless.
    lwstall  = memtorege & ((rte == rsd) | (rte == rtd));
    hit_e    = regwritee & (writerege != '0) &
               ((writerege == rsd) | (writerege == rtd));
    hit_m    = memtoregm & (writeregm != '0) &
               ((writeregm == rsd) | (writeregm == rtd));
    branchstall = branchd & (hit_e | hit_m);
    mdstall     = (mdopd | hiloreadd) & (md_busy | start_now);
    stall_any   = lwstall | branchstall | mdstall | memstall;

    stallf    = stall_any;
    stalld    = stall_any;
    stalle    = memstall;
    stallm    = memstall;
    flushe    = (lwstall | branchstall | mdstall) & ~memstall;
    flushd    = pcsrcd & ~stall_any;
    forwardad = (rsd != '0) & (rsd == writeregm) & regwritem;
    forwardbd = (rtd != '0) & (rtd == writeregm) & regwritem;

    if ((rse != '0) && (rse == writeregm) && regwritem)      forwardae = FWD_MEM;
    else if ((rse != '0) && (rse == writeregw) && regwritew) forwardae = FWD_WB;
    else                                                     forwardae = FWD_RF;

    if ((rte != '0) && (rte == writeregm) && regwritem)      forwardbe = FWD_MEM;
    else if ((rte != '0) && (rte == writeregw) && regwritew) forwardbe = FWD_WB;
    else                                                     forwardbe = FWD_RF;

    if (rst) begin
      stallf    = 1'b0;
      stalld    = 1'b0;
      stalle    = 1'b0;
      stallm    = 1'b0;
      flushd    = 1'b1;
      flushe    = 1'b1;
      forwardad = 1'b0;
      forwardbd = 1'b0;
      forwardae = FWD_RF;
      forwardbe = FWD_RF;
    end
  end

endmodule
